// File: rtl/sobel_merge_branch_block.sv
// -----------------------------------------------------------------------------
// sobel_merge_branch_block
//
// Merges NUM_PRED predecessor channels into one output register with fixed
// priority (lowest index wins). The registered item is then routed to one of
// two successors by bit 0 of its payload. Each channel owns a one-entry
// staging register so a producer whose item loses arbitration is never lost.
// Entry/exit counters track resident work-items, throttle acceptance at
// MAX_LIVE, and detect workgroup completion.
//
// Ports
//   clock           sole clock, rising edge
//   reset           synchronous, active-high; outranks start and handshakes
//   valid_in        per-channel valid
//   data_in         per-channel payload, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   stall_out       per-channel stall (channel's staging register is occupied)
//   valid_out_0/1   valid towards successor 0 (data_out[0]==0) / 1 (==1)
//   stall_in_0/1    stall from successor 0 / 1
//   data_out        payload shared by both successors
//   workgroup_size  exit count that completes a workgroup (0 = never)
//   start           one-cycle pulse opening a new workgroup
//   num_live        entries minus exits, modulo 2^32
//   wg_done         one-cycle pulse after the completing exit
//   invariant_valid high from the first accept of the current workgroup
// -----------------------------------------------------------------------------
module sobel_merge_branch_block #(
    parameter int NUM_PRED   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LIVE   = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PRED-1:0]            valid_in,
    input  logic [NUM_PRED*DATA_WIDTH-1:0] data_in,
    output logic [NUM_PRED-1:0]            stall_out,
    output logic                           valid_out_0,
    output logic                           valid_out_1,
    input  logic                           stall_in_0,
    input  logic                           stall_in_1,
    output logic [DATA_WIDTH-1:0]          data_out,
    input  logic [31:0]                    workgroup_size,
    input  logic                           start,
    output logic [31:0]                    num_live,
    output logic                           wg_done,
    output logic                           invariant_valid
);

    localparam logic [31:0] MAX_LIVE_W = 32'(MAX_LIVE);

    logic [NUM_PRED-1:0]   stg_v;
    logic [DATA_WIDTH-1:0] stg_d [NUM_PRED];
    logic                  out_v;
    logic [31:0]           entry_cnt;
    logic [31:0]           exit_cnt;
    logic [31:0]           live;

    logic [NUM_PRED-1:0]   cand_v;
    logic [NUM_PRED-1:0]   sel_oh;
    logic [NUM_PRED-1:0]   acc_oh;
    logic [NUM_PRED-1:0]   stg_load;
    logic [NUM_PRED-1:0]   stg_clr;
    logic [DATA_WIDTH-1:0] sel_d;
    logic                  sel_any;
    logic                  route_1;
    logic                  out_free;
    logic                  accept;
    logic                  exit_now;

    // A channel competes with its staged item if one is held, else with the
    // live input.
    assign cand_v = stg_v | valid_in;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it holding its old value, which would infer a latch.
        sel_oh  = '0;
        sel_d   = '0;
        sel_any = 1'b0;
        for (int i = 0; i < NUM_PRED; i++) begin
            if (cand_v[i] && !sel_any) begin
                sel_any   = 1'b1;
                sel_oh[i] = 1'b1;
                sel_d     = stg_v[i] ? stg_d[i] : data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign route_1  = data_out[0];
    assign live     = entry_cnt - exit_cnt;
    assign exit_now = out_v & (route_1 ? ~stall_in_1 : ~stall_in_0);
    // Only the stall of the successor the held item is routed to matters.
    assign out_free = ~out_v | (~route_1 & ~stall_in_0) | (route_1 & ~stall_in_1);
    // Throttle uses the registered count, so an exit frees a slot one cycle later.
    assign accept   = sel_any & out_free & (live < MAX_LIVE_W);

    assign acc_oh   = {NUM_PRED{accept}} & sel_oh;
    assign stg_clr  = acc_oh & stg_v;
    // A transfer that did not win goes to staging; an accepted direct item does not.
    assign stg_load = valid_in & ~stg_v & ~acc_oh;

    // Outputs are forced quiet while reset is asserted, not only after the edge.
    assign stall_out   = reset ? '0 : stg_v;
    assign valid_out_0 = ~reset & out_v & ~route_1;
    assign valid_out_1 = ~reset & out_v &  route_1;
    assign num_live    = reset ? 32'd0 : live;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            stg_v           <= '0;
            out_v           <= 1'b0;
            entry_cnt       <= 32'd0;
            exit_cnt        <= 32'd0;
            wg_done         <= 1'b0;
            invariant_valid <= 1'b0;
        end else begin
            stg_v <= (stg_v & ~stg_clr) | stg_load;

            if (accept) begin
                out_v <= 1'b1;
            end else if (exit_now) begin
                out_v <= 1'b0;
            end

            wg_done <= exit_now && (workgroup_size != 32'd0) &&
                       (exit_cnt + 32'd1 == workgroup_size);

            // start wins over a coincident count update.
            if (start) begin
                entry_cnt       <= 32'd0;
                exit_cnt        <= 32'd0;
                invariant_valid <= 1'b0;
            end else begin
                if (accept) begin
                    entry_cnt       <= entry_cnt + 32'd1;
                    invariant_valid <= 1'b1;
                end
                if (exit_now) begin
                    exit_cnt <= exit_cnt + 32'd1;
                end
            end
        end
    end

    // NOTE: payload registers are qualified by their valid bits, so they
    // carry no reset; this keeps the reset net off the wide datapath.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PRED; i++) begin
            if (stg_load[i]) begin
                stg_d[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (accept) begin
            data_out <= sel_d;
        end
    end

endmodule

// File: tb/tb_sobel_merge_branch_block.sv
// -----------------------------------------------------------------------------
// tb_sobel_merge_branch_block
//
// Two instances share all inputs: a main one (MAX_LIVE=16) and a throttled one
// (MAX_LIVE=1) so the live-count limit actually bites. A transaction-level
// model predicts accepts; accepted payloads are queued per instance and a
// negedge monitor pops and compares on every exit, alongside status outputs.
// -----------------------------------------------------------------------------
module tb_sobel_merge_branch_block;

    localparam int NP = 3;
    localparam int DW = 16;

    logic              clock;
    logic              reset;
    logic [NP-1:0]     valid_in;
    logic [NP*DW-1:0]  data_in;
    logic              stall_in_0;
    logic              stall_in_1;
    logic [31:0]       workgroup_size;
    logic              start;

    logic [NP-1:0] so_a, so_b;
    logic          v0_a, v1_a, v0_b, v1_b;
    logic [DW-1:0] do_a, do_b;
    logic [31:0]   live_a, live_b;
    logic          wg_a, wg_b, inv_a, inv_b;

    sobel_merge_branch_block #(.NUM_PRED(NP), .DATA_WIDTH(DW), .MAX_LIVE(16)) u_main (
        .clock(clock), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .stall_out(so_a), .valid_out_0(v0_a), .valid_out_1(v1_a),
        .stall_in_0(stall_in_0), .stall_in_1(stall_in_1), .data_out(do_a),
        .workgroup_size(workgroup_size), .start(start), .num_live(live_a),
        .wg_done(wg_a), .invariant_valid(inv_a)
    );

    sobel_merge_branch_block #(.NUM_PRED(NP), .DATA_WIDTH(DW), .MAX_LIVE(1)) u_thr (
        .clock(clock), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .stall_out(so_b), .valid_out_0(v0_b), .valid_out_1(v1_b),
        .stall_in_0(stall_in_0), .stall_in_1(stall_in_1), .data_out(do_b),
        .workgroup_size(workgroup_size), .start(start), .num_live(live_b),
        .wg_done(wg_b), .invariant_valid(inv_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    logic [31:0] wgs_r = 32'd3;

    // Reference model state, per instance.
    bit            m_stg_v [2][NP];
    logic [DW-1:0] m_stg_d [2][NP];
    bit            m_out_v [2];
    logic [DW-1:0] m_out_d [2];
    logic [31:0]   m_entry [2];
    logic [31:0]   m_exit  [2];
    bit            m_wg    [2];
    bit            m_inv   [2];

    // Expected visible outputs for the current cycle.
    logic [NP-1:0] e_so   [2];
    bit            e_v0   [2];
    bit            e_v1   [2];
    logic [31:0]   e_live [2];
    bit            e_wg   [2];
    bit            e_inv  [2];
    logic [DW-1:0] e_dout [2];

    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] max_live(input int u);
        return (u == 0) ? 32'd16 : 32'd1;
    endfunction

    function automatic bit all_idle();
        for (int u = 0; u < 2; u++) begin
            if (m_out_v[u] || (m_entry[u] != m_exit[u])) return 1'b0;
            for (int i = 0; i < NP; i++) if (m_stg_v[u][i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic predict(input int u);
        for (int i = 0; i < NP; i++) e_so[u][i] = !reset && m_stg_v[u][i];
        e_v0[u]   = !reset && m_out_v[u] && !m_out_d[u][0];
        e_v1[u]   = !reset && m_out_v[u] &&  m_out_d[u][0];
        e_live[u] = reset ? 32'd0 : m_entry[u] - m_exit[u];
        e_wg[u]   = m_wg[u];
        e_inv[u]  = m_inv[u];
        e_dout[u] = m_out_d[u];
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic step(input int u);
        int            sel;
        logic [DW-1:0] pay;
        bit            ex, acc;
        if (reset) begin
            for (int i = 0; i < NP; i++) m_stg_v[u][i] = 1'b0;
            m_out_v[u] = 1'b0;
            m_entry[u] = 32'd0;
            m_exit[u]  = 32'd0;
            m_wg[u]    = 1'b0;
            m_inv[u]   = 1'b0;
            if (u == 0) q0.delete(); else q1.delete();
            return;
        end
        sel = -1;
        pay = '0;
        for (int i = NP - 1; i >= 0; i--) if (m_stg_v[u][i] || valid_in[i]) sel = i;
        if (sel >= 0) pay = m_stg_v[u][sel] ? m_stg_d[u][sel] : data_in[sel*DW +: DW];
        ex  = m_out_v[u] && (m_out_d[u][0] ? !stall_in_1 : !stall_in_0);
        acc = (sel >= 0) && (!m_out_v[u] || ex) && ((m_entry[u] - m_exit[u]) < max_live(u));
        m_wg[u] = ex && (workgroup_size != 0) && (m_exit[u] + 1 == workgroup_size);
        for (int i = 0; i < NP; i++) begin
            if (acc && i == sel) begin
                m_stg_v[u][i] = 1'b0;
            end else if (valid_in[i] && !m_stg_v[u][i]) begin
                m_stg_v[u][i] = 1'b1;
                m_stg_d[u][i] = data_in[i*DW +: DW];
            end
        end
        if (acc) begin
            m_out_v[u] = 1'b1;
            m_out_d[u] = pay;
            if (u == 0) q0.push_back(pay); else q1.push_back(pay);
        end else if (ex) begin
            m_out_v[u] = 1'b0;
        end
        if (start) begin
            m_entry[u] = 32'd0;
            m_exit[u]  = 32'd0;
            m_inv[u]   = 1'b0;
        end else begin
            m_entry[u] = m_entry[u] + (acc ? 32'd1 : 32'd0);
            m_exit[u]  = m_exit[u]  + (ex  ? 32'd1 : 32'd0);
            if (acc) m_inv[u] = 1'b1;
        end
    endtask

    task automatic drive(input logic [NP-1:0] vin, input logic [NP*DW-1:0] din,
                         input logic s0, input logic s1, input logic st, input logic rst);
        valid_in       = vin;
        data_in        = din;
        stall_in_0     = s0;
        stall_in_1     = s1;
        start          = st;
        workgroup_size = wgs_r;
        reset          = rst;
        predict(0);
        predict(1);
        @(posedge clock);
        step(0);
        step(1);
        if (rst) mon_en = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [NP*DW-1:0] rand_data();
        logic [NP*DW-1:0] d;
        for (int i = 0; i < NP; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    task automatic mon_unit(input int u, input logic [NP-1:0] so, input logic v0, input logic v1,
                            input logic [DW-1:0] dout, input logic [31:0] live,
                            input logic wg, input logic inv);
        string         tag;
        logic [DW-1:0] exp_d;
        logic [1:0]    er;
        bit            empty;
        tag = (u == 0) ? "main" : "thr";
        check({tag, ".stall_out"},       64'(so),   64'(e_so[u]));
        check({tag, ".valid_out_0"},     64'(v0),   64'(e_v0[u]));
        check({tag, ".valid_out_1"},     64'(v1),   64'(e_v1[u]));
        check({tag, ".num_live"},        64'(live), 64'(e_live[u]));
        check({tag, ".wg_done"},         64'(wg),   64'(e_wg[u]));
        check({tag, ".invariant_valid"}, 64'(inv),  64'(e_inv[u]));
        if (e_v0[u] || e_v1[u]) check({tag, ".data_out"}, 64'(dout), 64'(e_dout[u]));
        if ((v0 && !stall_in_0) || (v1 && !stall_in_1)) begin
            empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.sb_exit: actual=exit of %0h required=no exit (nothing accepted)", tag, dout);
            end else begin
                exp_d = (u == 0) ? q0.pop_front() : q1.pop_front();
                er    = exp_d[0] ? 2'b10 : 2'b01;
                check({tag, ".sb_data"},  64'(dout),    64'(exp_d));
                check({tag, ".sb_route"}, 64'({v1, v0}), 64'(er));
            end
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            mon_unit(0, so_a, v0_a, v1_a, do_a, live_a, wg_a, inv_a);
            mon_unit(1, so_b, v0_b, v1_b, do_b, live_b, wg_b, inv_b);
        end
    end

    initial begin
        logic [NP-1:0] vin;
        bit            st, rst, s0, s1;
        int            pv, ps;

        // Reset, then open a workgroup of three.
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        wgs_r = 32'd3;
        drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Single item on channel 0.
        drive(3'b001, {16'h0, 16'h0, 16'h10}, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Collision: channel 0 wins, channel 1 staged; third exit ends the workgroup.
        drive(3'b011, {16'h0, 16'h3, 16'h2}, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Backpressure on successor 1 while all channels keep offering.
        drive(3'b001, {16'h0, 16'h0, 16'h5}, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive(3'b111, rand_data(), 1'b0, 1'b1, 1'b0, 1'b0);
        idle(8);
        // New workgroup clears the counters and invariant_valid.
        drive('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        // Fill staging and output, reset mid-stream, then a fresh item.
        for (int k = 0; k < 3; k++) drive(3'b111, rand_data(), 1'b1, 1'b1, 1'b0, 1'b0);
        drive(3'b111, rand_data(), 1'b1, 1'b1, 1'b0, 1'b1);
        drive(3'b001, {16'h0, 16'h0, 16'h10}, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic in phases of varying density and backpressure.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 200) % 4)
                0:       begin pv = 50; ps = 0;  end
                1:       begin pv = 90; ps = 30; end
                2:       begin pv = 70; ps = 85; end
                default: begin pv = 10; ps = 20; end
            endcase
            rst = ($urandom_range(0, 399) == 0);
            st  = 1'b0;
            if (!rst && all_idle() && $urandom_range(0, 5) == 0) begin
                st    = 1'b1;
                wgs_r = 32'($urandom_range(0, 4));
            end
            for (int i = 0; i < NP; i++) vin[i] = !st && ($urandom_range(0, 99) < pv);
            s0 = ($urandom_range(0, 99) < ps);
            s1 = ($urandom_range(0, 99) < ps);
            drive(vin, rand_data(), s0, s1, st, rst);
        end

        idle(20);
        check("main.sb_drained", 64'(q0.size()), 64'd0);
        check("thr.sb_drained",  64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
